mc_ctrl_fsm: RTL and testbench

Parametrised multicycle control unit for the MIPS-subset datapath. It decodes the latched instruction word and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, driving every datapath mux select and write strobe. Compared with the previous FSM, it adds a variable-latency memory handshake, beq, addi and jal/jr sequencing, illegal-opcode trapping and a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_ctrl_fsm_if.sv | 34 +++
 rtl/mc_ctrl_decode.sv | 105 ++++++++++
 rtl/mc_ctrl_fsm.sv | 51 +++++
 tb/tb_mc_ctrl_fsm.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encodings, opcode/funct constants, ALU codes, mux selects and opcode-to-state decode
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, BRANCH, JUMP, JAL1, JAL2, JR, TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_XORI = 6'h0E, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_SLT = 6'h2A, FN_JR = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3, ALU_PASSA = 3'd4;
  localparam logic [1:0] DST_RD = 2'd0, DST_RT = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] PC_SRC_DA = 2'd0, PC_SRC_RES = 2'd1, PC_SRC_ALU = 2'd2, PC_SRC_JMP = 2'd3;
  localparam logic [1:0] SRC_B_SEXT = 2'd0, SRC_B_DB = 2'd1, SRC_B_FOUR = 2'd2;
  localparam logic [1:0] PC_WE_NONE = 2'd0, PC_WE_ALWAYS = 2'd1, PC_WE_NZ = 2'd2, PC_WE_Z = 2'd3;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_in;
    logic [1:0] dst;
    logic       reg_in;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] pc_we;
  } ctrl_t;
  function automatic state_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
    case (opcode)
      OP_RTYPE: return (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) ? EXEC_R :
                       funct == FN_JR ? JR : TRAP;
      OP_ADDI, OP_XORI: return EXEC_I;
      OP_LW, OP_SW: return MEM_ADDR;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_J: return JUMP;
      OP_JAL: return JAL1;
      default: return TRAP;
    endcase
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller<->datapath bundle; master=controller (drives strobes/selects/status), slave=datapath (drives instruction, alu_zero, mem_ready)
interface mc_ctrl_fsm_if #(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W = 32
);
  logic [31:0]         instruction;
  logic                alu_zero;
  logic                mem_ready;
  logic                mem_req;
  logic [1:0]          pc_we;
  logic                mem_we;
  logic                ir_we;
  logic                reg_we;
  logic                mem_in;
  logic [1:0]          dst;
  logic                reg_in;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          pc_src;
  logic [3:0]          state_out;
  logic                illegal;
  logic [CNT_W-1:0]    retired;
  modport master (
    input  instruction, alu_zero, mem_ready,
    output mem_req, pc_we, mem_we, ir_we, reg_we, mem_in, dst, reg_in,
           alu_src_a, alu_src_b, alu_op, pc_src, state_out, illegal, retired
  );
  modport slave (
    output instruction, alu_zero, mem_ready,
    input  mem_req, pc_we, mem_we, ir_we, reg_we, mem_in, dst, reg_in,
           alu_src_a, alu_src_b, alu_op, pc_src, state_out, illegal, retired
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: next-state and Moore control decode; in: state, opcode, funct, mem_ready; out: next, ctrl
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_t     next,
  output ctrl_t      ctrl
);
  logic done;
  assign done = MEM_WAIT_EN ? mem_ready : 1'b1;
  always_comb begin
    next = state;
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.pc_src = PC_SRC_ALU;
        ctrl.ir_we = done;
        ctrl.pc_we = done ? PC_WE_ALWAYS : PC_WE_NONE;
        next = done ? DECODE : FETCH;
      end
      DECODE: next = decode_op(opcode, funct);
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_DB;
        ctrl.alu_op = funct == FN_SUB ? ALU_SUB : funct == FN_SLT ? ALU_SLT : ALU_ADD;
        next = R_WB;
      end
      R_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.dst = DST_RD;
        ctrl.reg_in = 1'b1;
        next = FETCH;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op = opcode == OP_XORI ? ALU_XOR : ALU_ADD;
        next = I_WB;
      end
      I_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.dst = DST_RT;
        ctrl.reg_in = 1'b1;
        next = FETCH;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        next = opcode == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_in = 1'b1;
        next = done ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        ctrl.reg_we = 1'b1;
        ctrl.dst = DST_RT;
        next = FETCH;
      end
      MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_in = 1'b1;
        ctrl.mem_we = 1'b1;
        next = done ? FETCH : MEM_WR;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_DB;
        ctrl.alu_op = ALU_SUB;
        ctrl.pc_src = PC_SRC_RES;
        ctrl.pc_we = opcode == OP_BEQ ? PC_WE_Z : PC_WE_NZ;
        next = FETCH;
      end
      JUMP: begin
        ctrl.pc_src = PC_SRC_JMP;
        ctrl.pc_we = PC_WE_ALWAYS;
        next = FETCH;
      end
      JAL1: begin
        ctrl.alu_op = ALU_PASSA;
        next = JAL2;
      end
      JAL2: begin
        ctrl.reg_we = 1'b1;
        ctrl.dst = DST_RA;
        ctrl.reg_in = 1'b1;
        ctrl.pc_src = PC_SRC_JMP;
        ctrl.pc_we = PC_WE_ALWAYS;
        next = FETCH;
      end
      JR: begin
        ctrl.pc_src = PC_SRC_DA;
        ctrl.pc_we = PC_WE_ALWAYS;
        next = FETCH;
      end
      TRAP: next = TRAP;
    endcase
  end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-subset controller; in: clk, reset, bus.instruction/alu_zero/mem_ready; out: bus strobes, selects, state_out, illegal, retired
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mc_ctrl_fsm_if.master bus
);
  state_t state, next;
  ctrl_t ctrl;
  logic illegal;
  logic [CNT_W-1:0] retired;
  mc_ctrl_decode #(.MEM_WAIT_EN(MEM_WAIT_EN)) u_decode (
    .state(state),
    .opcode(bus.instruction[31:26]),
    .funct(bus.instruction[5:0]),
    .mem_ready(bus.mem_ready),
    .next(next),
    .ctrl(ctrl)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= next;
      illegal <= illegal | (next == TRAP);
      retired <= retired + CNT_W'(state != FETCH && next == FETCH);
    end
  // reset is asynchronous, so strobes are masked combinationally to keep an aborted access silent
  assign bus.mem_req = ctrl.mem_req & ~reset;
  assign bus.mem_we = ctrl.mem_we & ~reset;
  assign bus.ir_we = ctrl.ir_we & ~reset;
  assign bus.reg_we = ctrl.reg_we & ~reset;
  assign bus.pc_we = reset ? PC_WE_NONE : ctrl.pc_we;
  assign bus.mem_in = ctrl.mem_in;
  assign bus.dst = ctrl.dst;
  assign bus.reg_in = ctrl.reg_in;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.alu_op = ALU_OP_W'(ctrl.alu_op);
  assign bus.pc_src = ctrl.pc_src;
  assign bus.state_out = state;
  assign bus.illegal = illegal;
  assign bus.retired = retired;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int chk = 0;
  int pass = 0;
  mc_ctrl_fsm_if #(.ALU_OP_W(3), .CNT_W(32)) bus ();
  mc_ctrl_fsm #(.ALU_OP_W(3), .CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic test_reset;
    bus.instruction = 32'h0;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b1;
    tick;
    tick;
    chk++; if (bus.state_out !== 4'd0) $display("FAIL reset_state got %0d want 0", bus.state_out); else pass++;
    chk++; if (bus.retired !== 32'd0 || bus.illegal !== 1'b0) $display("FAIL reset_status got retired=%0d illegal=%0b want 0/0", bus.retired, bus.illegal); else pass++;
    chk++; if ({bus.mem_req, bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_we} !== 6'b0) $display("FAIL reset_strobes got %b want 000000", {bus.mem_req, bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_we}); else pass++;
    chk++; if ({bus.alu_src_b, bus.pc_src} !== 4'b1010) $display("FAIL reset_selects got %b want 1010", {bus.alu_src_b, bus.pc_src}); else pass++;
    reset = 1'b0;
  endtask
  task automatic test_rtype;
    bus.instruction = 32'h00221820;
    #1;
    chk++; if ({bus.state_out, bus.mem_req, bus.ir_we, bus.pc_we} !== 7'b0000_1_1_01) $display("FAIL rtype_fetch got %b want 0000_1_1_01", {bus.state_out, bus.mem_req, bus.ir_we, bus.pc_we}); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd1) $display("FAIL rtype_decode got %0d want 1", bus.state_out); else pass++;
    tick;
    chk++; if ({bus.state_out, bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {4'd2, 1'b1, 2'd1, 3'd0}) $display("FAIL rtype_exec got %b", {bus.state_out, bus.alu_src_a, bus.alu_src_b, bus.alu_op}); else pass++;
    tick;
    chk++; if ({bus.state_out, bus.reg_we, bus.dst, bus.reg_in} !== {4'd3, 1'b1, 2'd0, 1'b1}) $display("FAIL rtype_wb got %b", {bus.state_out, bus.reg_we, bus.dst, bus.reg_in}); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd0 || bus.retired !== 32'd1) $display("FAIL rtype_retire got state=%0d retired=%0d want 0/1", bus.state_out, bus.retired); else pass++;
  endtask
  task automatic test_lw_wait;
    int held = 0;
    bus.instruction = 32'h8C220004;
    tick;
    tick;
    chk++; if (bus.state_out !== 4'd6) $display("FAIL lw_addr got %0d want 6", bus.state_out); else pass++;
    bus.mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (bus.state_out == 4'd7 && bus.mem_req === 1'b1 && bus.mem_in === 1'b1) held++;
      if (i == 3) bus.mem_ready = 1'b1;
      tick;
    end
    chk++; if (held !== 4) $display("FAIL lw_mem_req_held got %0d want 4", held); else pass++;
    chk++; if ({bus.state_out, bus.reg_we, bus.dst, bus.reg_in, bus.mem_req} !== {4'd8, 1'b1, 2'd1, 1'b0, 1'b0}) $display("FAIL lw_wb got %b", {bus.state_out, bus.reg_we, bus.dst, bus.reg_in, bus.mem_req}); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd0 || bus.retired !== 32'd2) $display("FAIL lw_retire got state=%0d retired=%0d want 0/2", bus.state_out, bus.retired); else pass++;
  endtask
  task automatic test_branch;
    logic taken;
    bus.alu_zero = 1'b1;
    bus.instruction = 32'h14220003;
    tick;
    tick;
    taken = bus.pc_we == 2'd1 || (bus.pc_we == 2'd2 && !bus.alu_zero) || (bus.pc_we == 2'd3 && bus.alu_zero);
    chk++; if ({bus.state_out, bus.pc_we, bus.pc_src, bus.alu_op} !== {4'd10, 2'd2, 2'd1, 3'd1}) $display("FAIL bne_branch got %b", {bus.state_out, bus.pc_we, bus.pc_src, bus.alu_op}); else pass++;
    chk++; if (taken !== 1'b0) $display("FAIL bne_pc_update got %0b want 0", taken); else pass++;
    tick;
    bus.instruction = 32'h10220003;
    tick;
    tick;
    taken = bus.pc_we == 2'd1 || (bus.pc_we == 2'd2 && !bus.alu_zero) || (bus.pc_we == 2'd3 && bus.alu_zero);
    chk++; if ({bus.state_out, bus.pc_we} !== {4'd10, 2'd3}) $display("FAIL beq_branch got %b", {bus.state_out, bus.pc_we}); else pass++;
    chk++; if (taken !== 1'b1) $display("FAIL beq_pc_update got %0b want 1", taken); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd0 || bus.retired !== 32'd4) $display("FAIL branch_retire got state=%0d retired=%0d want 0/4", bus.state_out, bus.retired); else pass++;
    bus.alu_zero = 1'b0;
  endtask
  task automatic test_jal;
    bus.instruction = 32'h0C000010;
    bus.mem_ready = 1'b0;
    #1;
    chk++; if ({bus.mem_req, bus.ir_we, bus.pc_we} !== 4'b1_0_00) $display("FAIL fetch_stall got %b want 1000", {bus.mem_req, bus.ir_we, bus.pc_we}); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd0) $display("FAIL fetch_hold got %0d want 0", bus.state_out); else pass++;
    bus.mem_ready = 1'b1;
    tick;
    tick;
    chk++; if ({bus.state_out, bus.alu_src_a, bus.alu_op} !== {4'd12, 1'b0, 3'd4}) $display("FAIL jal1 got %b", {bus.state_out, bus.alu_src_a, bus.alu_op}); else pass++;
    tick;
    chk++; if ({bus.state_out, bus.dst, bus.reg_we, bus.pc_src, bus.pc_we} !== {4'd13, 2'd2, 1'b1, 2'd3, 2'd1}) $display("FAIL jal2 got %b", {bus.state_out, bus.dst, bus.reg_we, bus.pc_src, bus.pc_we}); else pass++;
    tick;
    chk++; if (bus.retired !== 32'd5) $display("FAIL jal_retire got %0d want 5", bus.retired); else pass++;
  endtask
  task automatic test_jr;
    bus.instruction = 32'h03E00008;
    tick;
    tick;
    chk++; if ({bus.state_out, bus.pc_we, bus.pc_src} !== {4'd14, 2'd1, 2'd0}) $display("FAIL jr got %b", {bus.state_out, bus.pc_we, bus.pc_src}); else pass++;
    tick;
    chk++; if (bus.state_out !== 4'd0 || bus.retired !== 32'd6) $display("FAIL jr_retire got state=%0d retired=%0d want 0/6", bus.state_out, bus.retired); else pass++;
  endtask
  task automatic test_reset_mid_wait;
    bus.instruction = 32'hAC220004;
    tick;
    tick;
    bus.mem_ready = 1'b0;
    tick;
    chk++; if ({bus.state_out, bus.mem_req, bus.mem_we, bus.mem_in} !== {4'd9, 3'b111}) $display("FAIL sw_wr got %b", {bus.state_out, bus.mem_req, bus.mem_we, bus.mem_in}); else pass++;
    tick;
    chk++; if ({bus.state_out, bus.mem_we} !== {4'd9, 1'b1}) $display("FAIL sw_wait got %b", {bus.state_out, bus.mem_we}); else pass++;
    #2 reset = 1'b1;
    #1;
    chk++; if ({bus.mem_we, bus.mem_req} !== 2'b00) $display("FAIL abort_strobes got %b want 00", {bus.mem_we, bus.mem_req}); else pass++;
    chk++; if (bus.state_out !== 4'd0 || bus.retired !== 32'd0) $display("FAIL abort_state got state=%0d retired=%0d want 0/0", bus.state_out, bus.retired); else pass++;
    bus.mem_ready = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic test_trap;
    bus.instruction = 32'hFC000000;
    tick;
    tick;
    chk++; if (bus.state_out !== 4'd15 || bus.illegal !== 1'b1) $display("FAIL trap_enter got state=%0d illegal=%0b want 15/1", bus.state_out, bus.illegal); else pass++;
    for (int i = 0; i < 20; i++) begin
      chk++; if ({bus.state_out, bus.mem_req, bus.mem_we, bus.ir_we, bus.reg_we, bus.pc_we} !== {4'd15, 6'b0}) $display("FAIL trap_hold cycle %0d got %b", i, {bus.state_out, bus.mem_req, bus.mem_we, bus.ir_we, bus.reg_we, bus.pc_we}); else pass++;
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk++; if (bus.state_out !== 4'd0 || bus.illegal !== 1'b0) $display("FAIL trap_clear got state=%0d illegal=%0b want 0/0", bus.state_out, bus.illegal); else pass++;
    chk++; if (bus.mem_req !== 1'b1) $display("FAIL trap_refetch got %0b want 1", bus.mem_req); else pass++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_rtype;
    test_lw_wait;
    test_branch;
    test_jal;
    test_jr;
    test_reset_mid_wait;
    test_trap;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
